// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
// Shares one fixed-latency single-precision multiplier core between two
// requesters. Round-robin grant, tag pipeline that routes each result back to
// its owner, one-entry response register and sticky status per requester.
//
// Ports
//   clk, rst             clock (rising edge), async active-low reset
//   req_valid_i/ready_o  per-requester request handshake (ready is the grant)
//   req_a_i, req_b_i     operands, requester i at [32i+31:32i]
//   mul_valid_o/a_o/b_o  operation issued to the core (operands zero when idle)
//   mul_z_i/status_i     core result, LAT cycles after issue
//   rsp_valid_o/ready_i  per-requester response handshake
//   rsp_z_o/status_o     held result and its flags, requester i at slice i
//   sticky_o/clr_i       OR-accumulated flags and their per-requester clear
//
// state    | meaning
// IDLE     | no operation outstanding, eligible for a grant
// INFLIGHT | operation issued, tag travelling through the core pipeline
// HOLD     | result captured, waiting for the response handshake
module fp_mult_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  output logic        mul_valid_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [31:0] mul_z_i,
  input  logic [5:0]  mul_status_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [63:0] rsp_z_o,
  output logic [11:0] rsp_status_o,
  output logic [11:0] sticky_o,
  input  logic [1:0]  sticky_clr_i
);

  typedef enum logic [1:0] {IDLE, INFLIGHT, HOLD} state_t;

  state_t         state_q [2];
  logic           last_q;
  logic [LAT-1:0] tag_v_q;
  logic [LAT-1:0] tag_id_q;
  logic [31:0]    rsp_z_q      [2];
  logic [5:0]     rsp_status_q [2];
  logic [5:0]     sticky_q     [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] cap;

  always_comb begin
    elig  = '0;
    cap   = '0;
    grant = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid_i[i] && (state_q[i] == IDLE);
      cap[i]  = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == 1'(i));
    end
    // Grant is suppressed while reset is asserted so nothing reaches the core.
    if (rst) begin
      if (elig == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign req_ready_o = grant;
  assign mul_valid_o = |grant;

  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    if (grant[0]) begin
      mul_a_o = req_a_i[31:0];
      mul_b_o = req_b_i[31:0];
    end else if (grant[1]) begin
      mul_a_o = req_a_i[63:32];
      mul_b_o = req_b_i[63:32];
    end
  end

  always_comb begin
    rsp_valid_o  = '0;
    rsp_z_o      = '0;
    rsp_status_o = '0;
    sticky_o     = '0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_o[i]         = (state_q[i] == HOLD);
      rsp_z_o[32*i +: 32]    = rsp_z_q[i];
      rsp_status_o[6*i +: 6] = rsp_status_q[i];
      sticky_o[6*i +: 6]     = sticky_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= 1'b1;
      tag_v_q  <= '0;
      tag_id_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i]      <= IDLE;
        rsp_z_q[i]      <= '0;
        rsp_status_q[i] <= '0;
        sticky_q[i]     <= '0;
      end
    end else begin
      if (|grant) last_q <= grant[1];

      tag_v_q[0]  <= |grant;
      tag_id_q[0] <= grant[1];
      for (int k = 1; k < LAT; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end

      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          IDLE:     if (grant[i]) state_q[i] <= INFLIGHT;
          INFLIGHT: if (cap[i]) state_q[i] <= HOLD;
          HOLD:     if (rsp_ready_i[i]) state_q[i] <= IDLE;
          default:  state_q[i] <= IDLE;
        endcase

        if (cap[i]) begin
          rsp_z_q[i]      <= mul_z_i;
          rsp_status_q[i] <= mul_status_i;
        end

        // A clear does not drop flags captured in the same cycle.
        sticky_q[i] <= (sticky_clr_i[i] ? 6'd0 : sticky_q[i]) |
                       (cap[i] ? mul_status_i : 6'd0);
      end
    end
  end

endmodule
